// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arbitrating N-channel multiplexer: mode encoding
// and elaboration-time parameter sanity checks.
package arb_mux_pkg;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } mode_e;

    // Channel count must be a power of two so index arithmetic wraps for free.
    function automatic bit n_is_legal(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit width_is_legal(input int w);
        return w >= 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotates requests so ptr is bit 0, takes the lowest set
// bit, then rotates the one-hot result back into channel order.
module rr_arbiter #(
    parameter  int N    = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx
);

    logic [2*N-1:0]  req_dbl;
    logic [2*N-1:0]  gnt_dbl;
    logic [N-1:0]    rot_req;
    logic [N-1:0]    rot_oh;
    logic [SELW-1:0] rot_idx;

    assign req_dbl = {req, req} >> ptr;
    assign rot_req = req_dbl[N-1:0];
    assign rot_oh  = rot_req & (~rot_req + N'(1));
    assign gnt_dbl = {rot_oh, rot_oh} << ptr;
    assign grant   = gnt_dbl[2*N-1:N];

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it holding its old value (no latch).
    always_comb begin
        rot_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (rot_oh[i]) rot_idx = SELW'(i);
        end
    end

    // Index wraps modulo N because N is a power of two.
    assign idx = rot_idx + ptr;

endmodule

// File: rtl/arb_mux_n.sv
// Registered N-channel arbitrating multiplexer with valid/ready handshakes,
// round-robin or fixed-select, one-entry output register.
module arb_mux_n
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int N     = 8,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);

    if (!n_is_legal(N)) begin : g_bad_n
        $error("arb_mux_n: N must be a power of two and at least 2");
    end
    if (!width_is_legal(WIDTH)) begin : g_bad_width
        $error("arb_mux_n: WIDTH must be at least 1");
    end
    if (SELW != $clog2(N)) begin : g_bad_selw
        $error("arb_mux_n: SELW is derived from N and must not be overridden");
    end

    mode_e            cur_mode;
    logic [SELW-1:0]  ptr;
    logic [N-1:0]     rr_grant;
    logic [SELW-1:0]  rr_idx;
    logic [N-1:0]     fixed_grant;
    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] sel_data;
    logic             free;
    logic             xfer;

    assign cur_mode = mode_e'(mode);

    rr_arbiter #(.N(N)) u_rr (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    always_comb begin
        fixed_grant      = '0;
        fixed_grant[sel] = in_valid[sel];
    end

    assign grant     = (cur_mode == MODE_FIXED) ? fixed_grant : rr_grant;
    assign grant_idx = (cur_mode == MODE_FIXED) ? sel : rr_idx;

    // Slot is free when empty or being drained this cycle; reset blocks all accepts.
    assign free     = !out_valid || out_ready;
    assign in_ready = (free && !reset) ? grant : '0;
    assign xfer     = |in_ready;

    // One-hot AND-OR select; grant is one-hot so at most one term contributes.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            sel_data = sel_data | (in_data[k*WIDTH +: WIDTH] & {WIDTH{grant[k]}});
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_sel   <= grant_idx;
                if (cur_mode == MODE_RR) ptr <= grant_idx + SELW'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: directed vector table, fairness sequence,
// then randomized traffic against a behavioural model.
module tb_arb_mux_n;

    localparam int N     = 8;
    localparam int WIDTH = 64;
    localparam int SELW  = 3;

    logic               clk;
    logic               reset;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    arb_mux_n #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_ptr   = 0;
    bit          m_valid = 0;
    logic [63:0] m_data  = '0;
    int          m_sel   = 0;

    typedef struct {
        logic        rst;
        logic        md;
        logic [2:0]  s;
        logic [7:0]  vld;
        logic        ordy;
        logic [7:0]  e_rdy;
        logic        e_ov;
        logic [2:0]  e_os;
        logic [63:0] e_od;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_grant();
        logic [7:0] g;
        g = '0;
        if (reset || !(!m_valid || out_ready)) return g;
        if (mode) begin
            if (in_valid[sel]) g[sel] = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (in_valid[c]) begin
                    g[c] = 1'b1;
                    return g;
                end
            end
        end
        return g;
    endfunction

    task automatic model_step(input logic [7:0] g);
        if (reset) begin
            m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
        end else if (g != 0) begin
            int k;
            k = 0;
            for (int i = 0; i < N; i++) if (g[i]) k = i;
            m_valid = 1;
            m_data  = in_data[k*WIDTH +: WIDTH];
            m_sel   = k;
            if (!mode) m_ptr = (k + 1) % N;
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    // One clock: drive inputs, check in_ready before the edge, outputs after it.
    task automatic tick(input logic r, input logic md, input logic [2:0] s,
                        input logic [7:0] v, input logic ordy, output logic [7:0] obs_rdy);
        logic [7:0] exp_rdy;
        reset = r; mode = md; sel = s; in_valid = v; out_ready = ordy;
        #1;
        exp_rdy = model_grant();
        obs_rdy = in_ready;
        check("model_in_ready", {56'd0, in_ready}, {56'd0, exp_rdy});
        @(posedge clk);
        model_step(exp_rdy);
        #1;
        check("model_out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        check("model_out_sel", {61'd0, out_sel}, 64'(m_sel));
        check("model_out_data", out_data, m_data);
    endtask

    function automatic vec_t mk(input logic r, input logic md, input logic [2:0] s,
                                input logic [7:0] v, input logic o, input logic [7:0] er,
                                input logic eov, input logic [2:0] eos, input logic [63:0] eod);
        vec_t t;
        t.rst = r; t.md = md; t.s = s; t.vld = v; t.ordy = o;
        t.e_rdy = er; t.e_ov = eov; t.e_os = eos; t.e_od = eod;
        return t;
    endfunction

    logic [7:0] obs;
    int         gcount[N];

    initial begin
        reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1;
        for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = 64'h100 + 64'(k);

        // reset then idle
        vecs.push_back(mk(1, 0, 0, 8'hFF, 1, 8'h00, 0, 0, 64'h0));
        vecs.push_back(mk(1, 0, 0, 8'hFF, 1, 8'h00, 0, 0, 64'h0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 64'h0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 64'h0));
        // full-load rotation 0..7,0
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(0, 0, 0, 8'hFF, 1, 8'(1 << (i % 8)), 1, 3'(i % 8), 64'h100 + 64'(i % 8)));
        // wrap and skip: grant 5 -> ptr 6 -> grant 0 -> grant 2
        vecs.push_back(mk(0, 0, 0, 8'h20, 1, 8'h20, 1, 5, 64'h105));
        vecs.push_back(mk(0, 0, 0, 8'h05, 1, 8'h01, 1, 0, 64'h100));
        vecs.push_back(mk(0, 0, 0, 8'h05, 1, 8'h04, 1, 2, 64'h102));
        // backpressure holding channel 3
        vecs.push_back(mk(0, 0, 0, 8'h08, 1, 8'h08, 1, 3, 64'h103));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 0, 8'hFF, 0, 8'h00, 1, 3, 64'h103));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 1, 8'h10, 1, 4, 64'h104));
        // fixed select 5; then drain; then RR resumes from frozen ptr 5
        vecs.push_back(mk(0, 1, 5, 8'hFF, 1, 8'h20, 1, 5, 64'h105));
        vecs.push_back(mk(0, 1, 5, 8'hFF, 1, 8'h20, 1, 5, 64'h105));
        vecs.push_back(mk(0, 1, 5, 8'hDF, 1, 8'h00, 0, 5, 64'h105));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 1, 8'h20, 1, 5, 64'h105));
        // mid-operation reset with ptr 4 and a held word
        vecs.push_back(mk(0, 0, 0, 8'h08, 1, 8'h08, 1, 3, 64'h103));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 0, 8'h00, 1, 3, 64'h103));
        vecs.push_back(mk(1, 0, 0, 8'hFF, 0, 8'h00, 0, 0, 64'h0));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 0, 8'h01, 1, 0, 64'h100));

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].md, vecs[i].s, vecs[i].vld, vecs[i].ordy, obs);
            check($sformatf("vec%0d_in_ready", i), {56'd0, obs}, {56'd0, vecs[i].e_rdy});
            check($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
            check($sformatf("vec%0d_out_sel", i), {61'd0, out_sel}, {61'd0, vecs[i].e_os});
            check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
        end

        // fairness: 2N cycles all valid, each channel granted exactly twice
        for (int k = 0; k < N; k++) gcount[k] = 0;
        for (int c = 0; c < 2 * N; c++) begin
            tick(0, 0, 0, 8'hFF, 1, obs);
            for (int k = 0; k < N; k++) if (obs[k]) gcount[k]++;
        end
        for (int k = 0; k < N; k++)
            check($sformatf("fair_ch%0d", k), 64'(gcount[k]), 64'd2);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = {$urandom, $urandom};
            tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                 3'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 3) != 0), obs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
